cl_axi_default_slave: RTL and testbench

- Parametrised AXI4 slave endpoint for CL interfaces that are present but unused, e.g. the PCIe slave port and DDR ports not wired to user logic.
- Replaces constant tie-offs. Every request is accepted and answered with a legal error response, so the shell never hangs on an unused port.
- Counts the rejected accesses and captures the last offending address for debug readout.
- One write channel and one read channel per instance. Instantiate one per unused port.

---
 rtl/cl_axi_dflt_pkg.sv | 19 +
 rtl/cl_sat_cnt.sv | 19 +
 rtl/cl_axi_default_slave.sv | 178 +++++++++++++++++
 tb/tb_cl_axi_default_slave.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_axi_dflt_pkg.sv
// rtl/cl_axi_dflt_pkg.sv - shared types and response codes for the AXI default slave
package cl_axi_dflt_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/cl_sat_cnt.sv
// rtl/cl_sat_cnt.sv - saturating incrementer with synchronous active-low clear
module cl_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cl_axi_default_slave.sv
// rtl/cl_axi_default_slave.sv - AXI4 endpoint that accepts everything and answers with an error response
module cl_axi_default_slave
    import cl_axi_dflt_pkg::*;
#(
    parameter int          ID_WIDTH   = 5,
    parameter int          ADDR_WIDTH = 64,
    parameter int          DATA_WIDTH = 512,
    parameter logic [1:0]  RESP_CODE  = AXI_RESP_DECERR,
    parameter logic [31:0] RD_PATTERN = 32'hDEAD_BEEF,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [CNT_WIDTH-1:0]    wr_err_cnt,
    output logic [CNT_WIDTH-1:0]    rd_err_cnt,
    output logic [ADDR_WIDTH-1:0]   last_err_addr,
    output logic                    last_err_is_wr,
    output logic                    wlast_mismatch
);

    w_state_e      w_state, w_next;
    r_state_e      r_state, r_next;
    logic          active_q;
    logic [7:0]    awlen_q;
    logic [7:0]    beat_cnt;
    logic [7:0]    remaining;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic          unused_inputs;

    assign unused_inputs = ^{wdata, wstrb};

    assign bresp = RESP_CODE;
    assign rresp = RESP_CODE;
    assign rdata = {(DATA_WIDTH/32){RD_PATTERN}};

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign b_hs  = bvalid & bready;
    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;

    // Readies are held low during reset and for the first cycle after it.
    always_ff @(posedge clk) begin
        if (!rst_n) active_q <= 1'b0;
        else        active_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state        <= W_IDLE;
            bid            <= '0;
            awlen_q        <= '0;
            beat_cnt       <= '0;
            wlast_mismatch <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                bid      <= awid;
                awlen_q  <= awlen;
                beat_cnt <= '0;
            end else if (w_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (w_hs && wlast && (beat_cnt != awlen_q)) wlast_mismatch <= 1'b1;
        end
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = active_q;
                if (awvalid && active_q) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            rid       <= '0;
            remaining <= '0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                rid       <= arid;
                remaining <= arlen;
            end else if (r_hs && (remaining != 8'd0)) begin
                remaining <= remaining - 8'd1;
            end
        end
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = active_q;
                if (arvalid && active_q) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (remaining == 8'd0);
                if (rready && (remaining == 8'd0)) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // A simultaneous AW and AR capture reports the write address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_err_addr  <= '0;
            last_err_is_wr <= 1'b0;
        end else if (aw_hs) begin
            last_err_addr  <= awaddr;
            last_err_is_wr <= 1'b1;
        end else if (ar_hs) begin
            last_err_addr  <= araddr;
            last_err_is_wr <= 1'b0;
        end
    end

    cl_sat_cnt #(.W(CNT_WIDTH)) u_wr_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (b_hs),
        .cnt   (wr_err_cnt)
    );

    cl_sat_cnt #(.W(CNT_WIDTH)) u_rd_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (r_hs & rlast),
        .cnt   (rd_err_cnt)
    );

endmodule

// File: tb/tb_cl_axi_default_slave.sv
// tb/tb_cl_axi_default_slave.sv - directed self-checking bench for cl_axi_default_slave
module tb_cl_axi_default_slave;

    localparam int DW = 128;
    localparam logic [DW-1:0] PAT = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    awid, arid, bid, rid;
    logic [63:0]   awaddr, araddr, last_err_addr;
    logic [7:0]    awlen, arlen;
    logic          awvalid, awready, wlast, wvalid, wready;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready, arvalid, arready, rlast, rvalid, rready;
    logic [3:0]    wr_err_cnt, rd_err_cnt;
    logic          last_err_is_wr, wlast_mismatch;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cl_axi_default_slave #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .wr_err_cnt(wr_err_cnt), .rd_err_cnt(rd_err_cnt),
        .last_err_addr(last_err_addr), .last_err_is_wr(last_err_is_wr),
        .wlast_mismatch(wlast_mismatch)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic [4:0] id, input logic [63:0] a, input logic [7:0] len);
        bit ok = 0;
        awid = id; awaddr = a; awlen = len; awvalid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (awready) begin ok = 1; step(); break; end
            step();
        end
        awvalid = 1'b0;
        chk("aw_handshake", ok, 1);
    endtask

    task automatic ar_send(input logic [4:0] id, input logic [63:0] a, input logic [7:0] len);
        bit ok = 0;
        arid = id; araddr = a; arlen = len; arvalid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (arready) begin ok = 1; step(); break; end
            step();
        end
        arvalid = 1'b0;
        chk("ar_handshake", ok, 1);
    endtask

    task automatic w_send(input int n);
        int ok_beats = 0;
        for (int b = 0; b < n; b++) begin
            wvalid = 1'b1;
            wlast  = (b == n - 1);
            wdata  = {4{$urandom}};
            for (int k = 0; k < 20; k++) begin
                if (wready) begin ok_beats++; step(); break; end
                step();
            end
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        chk("w_beats_accepted", ok_beats, n);
    endtask

    task automatic b_recv(input logic [4:0] id);
        bit ok = 0;
        bready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (bvalid) begin
                ok = 1;
                chk("bid", bid, id);
                chk("bresp", bresp, 2'b11);
                step();
                break;
            end
            step();
        end
        bready = 1'b0;
        chk("b_handshake", ok, 1);
        chk("bvalid_dropped", bvalid, 0);
    endtask

    task automatic r_recv(input logic [4:0] id, input int n, input bit toggle);
        int beats = 0;
        int bad   = 0;
        int cyc   = 0;
        bit done  = 0;
        while (!done && cyc < 2000) begin
            rready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (rvalid) begin
                if (rdata !== PAT || rid !== id || rresp !== 2'b11) bad++;
                if (rready) begin
                    beats++;
                    if (rlast !== (beats == n)) bad++;
                    if (rlast) done = 1;
                end
            end
            step();
            cyc++;
        end
        rready = 1'b0;
        chk("r_done", done, 1);
        chk("r_beat_count", beats, n);
        chk("r_beat_errors", bad, 0);
        chk("rvalid_dropped", rvalid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '1; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;

        step(); step();
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        rst_n = 1'b1;
        repeat (10) step();
        chk("idle_awready", awready, 1);
        chk("idle_arready", arready, 1);
        chk("idle_wready", wready, 0);
        chk("idle_bvalid", bvalid, 0);
        chk("idle_rvalid", rvalid, 0);
        chk("idle_wr_cnt", wr_err_cnt, 0);
        chk("idle_rd_cnt", rd_err_cnt, 0);
        chk("idle_mismatch", wlast_mismatch, 0);
        chk("idle_last_addr", last_err_addr, 0);
        chk("idle_bresp", bresp, 2'b11);
        chk("idle_rdata", rdata, PAT);

        // Early W beat without AW must stall
        wvalid = 1'b1; wlast = 1'b1;
        step(); step();
        chk("w_stall_before_aw", wready, 0);
        wvalid = 1'b0; wlast = 1'b0;

        // Correct 4-beat write
        aw_send(5'h3, 64'h1000, 8'd3);
        chk("w_wready_after_aw", wready, 1);
        chk("w_last_addr", last_err_addr, 64'h1000);
        chk("w_last_is_wr", last_err_is_wr, 1);
        w_send(4);
        chk("w_bvalid_after_last", bvalid, 1);
        chk("w_wready_in_resp", wready, 0);
        b_recv(5'h3);
        chk("w_cnt_1", wr_err_cnt, 1);
        chk("w_mismatch_clean", wlast_mismatch, 0);
        chk("w_awready_again", awready, 1);

        // 256-beat read with rready toggling
        ar_send(5'h7, 64'h2000, 8'd255);
        chk("r_last_is_rd", last_err_is_wr, 0);
        chk("r_last_addr", last_err_addr, 64'h2000);
        r_recv(5'h7, 256, 1'b1);
        chk("r_cnt_1", rd_err_cnt, 1);

        // Early wlast sets sticky mismatch, persists through a clean burst
        aw_send(5'h1, 64'h3000, 8'd3);
        w_send(2);
        chk("mm_bvalid_after_2", bvalid, 1);
        chk("mm_set", wlast_mismatch, 1);
        b_recv(5'h1);
        aw_send(5'h2, 64'h3100, 8'd3);
        w_send(4);
        b_recv(5'h2);
        chk("mm_sticky", wlast_mismatch, 1);
        chk("w_cnt_3", wr_err_cnt, 3);

        // Simultaneous AW and AR
        awid = 5'h6; awaddr = 64'hA0; awlen = 8'd0; awvalid = 1'b1;
        arid = 5'h2; araddr = 64'hB0; arlen = 8'd0; arvalid = 1'b1;
        step();
        awvalid = 1'b0; arvalid = 1'b0;
        chk("sim_aw_taken", awready, 0);
        chk("sim_ar_taken", arready, 0);
        chk("sim_last_addr", last_err_addr, 64'hA0);
        chk("sim_last_is_wr", last_err_is_wr, 1);
        w_send(1);
        b_recv(5'h6);
        r_recv(5'h2, 1, 1'b0);
        chk("sim_rd_cnt", rd_err_cnt, 2);
        chk("sim_wr_cnt", wr_err_cnt, 4);

        // Saturation of 4-bit read counter
        for (int i = 0; i < 13; i++) begin
            ar_send(5'h4, 64'hC000 + 64'(i), 8'd0);
            r_recv(5'h4, 1, 1'b0);
        end
        chk("sat_cnt_15", rd_err_cnt, 4'hF);
        chk("sat_last_addr", last_err_addr, 64'hC00C);
        for (int i = 0; i < 2; i++) begin
            ar_send(5'h4, 64'hD000, 8'd0);
            r_recv(5'h4, 1, 1'b0);
        end
        chk("sat_cnt_17", rd_err_cnt, 4'hF);

        // Reset during beat 2 of an 8-beat read
        ar_send(5'h9, 64'h5000, 8'd7);
        rready = 1'b1;
        step();
        chk("rst_mid_rvalid_b2", rvalid, 1);
        chk("rst_mid_rlast_b2", rlast, 0);
        rready = 1'b0;
        rst_n = 1'b0;
        step();
        chk("rst_mid_rvalid", rvalid, 0);
        chk("rst_mid_rd_cnt", rd_err_cnt, 0);
        chk("rst_mid_wr_cnt", wr_err_cnt, 0);
        chk("rst_mid_mismatch", wlast_mismatch, 0);
        rst_n = 1'b1;
        step();
        ar_send(5'h4, 64'h6000, 8'd1);
        r_recv(5'h4, 2, 1'b0);
        chk("post_rst_rd_cnt", rd_err_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
